dvi_link_ctrl: RTL and testbench

Start-up and supervision controller for the DVI transmit path in the 5x bit-clock domain. It watches a pixel-clock heartbeat and releases the x5-side reset of the three TMDS lane serialisers only once the pixel clock is stable. It then gates the lane outputs on, and tears the link down and retries on any pixel-clock fault. It sits between the clock/reset generator and the per-lane serialisers, and drives their shared x5 reset and output enable.

---
 rtl/dvi_link_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dvi_link_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_link_ctrl.sv
// ============================================================================
// Module   : dvi_link_ctrl
// Brief    : Pixel-clock supervision and lane reset/enable sequencing for the
//            DVI transmit path, running in the 5x bit-clock domain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dvi_link_ctrl #(
    parameter int LOCK_EDGES    = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int HOLD_CYCLES   = 32,
    parameter int W_ERR         = 8
) (
    input  logic             clk_x5,
    input  logic             rst_n_x5,
    input  logic             enable,
    input  logic             pix_toggle,
    input  logic             clr_err,
    output logic             lane_rst_n,
    output logic             out_en,
    output logic             locked,
    output logic [2:0]       state,
    output logic [W_ERR-1:0] err_count
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_WAIT_CLK = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_EDGES - 1);
    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);
    localparam logic [9:0] HOLD_LAST   = 10'(HOLD_CYCLES - 1);

    logic             en_s1_q, en_s2_q;
    logic             pt_s1_q, pt_s2_q, pt_s3_q;
    logic [3:0]       ivl_q, ivl_d;
    state_t           state_q, state_d;
    logic [7:0]       good_cnt_q, good_cnt_d;
    logic [9:0]       tmr_q, tmr_d;
    logic [W_ERR-1:0] err_q, err_d;
    logic             lane_rst_n_q, lane_rst_n_d;
    logic             out_en_q, out_en_d;
    logic             locked_q, locked_d;

    logic hb_edge;
    logic good_edge;
    logic fault;
    logic err_inc;

    // Heartbeat measurement: the interval is judged on the pre-load ivl value.
    always_comb begin
        hb_edge   = pt_s2_q ^ pt_s3_q;
        good_edge = hb_edge && (ivl_q >= 4'd4) && (ivl_q <= 4'd6);
        // ivl only passes through 8 once per gap, so the timeout fires once
        fault     = (hb_edge && !good_edge) || (!hb_edge && (ivl_q == 4'd8));
        if (hb_edge) begin
            ivl_d = 4'd1;
        end else if (ivl_q != 4'd15) begin
            ivl_d = ivl_q + 4'd1;
        end else begin
            ivl_d = ivl_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        tmr_d      = tmr_q;
        err_inc    = 1'b0;
        if (!en_s2_q) begin
            state_d    = ST_OFF;
            good_cnt_d = 8'd0;
            tmr_d      = 10'd0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d    = ST_WAIT_CLK;
                    good_cnt_d = 8'd0;
                end
                ST_WAIT_CLK: begin
                    if (fault) begin
                        good_cnt_d = 8'd0;
                    end else if (good_edge) begin
                        if (good_cnt_q == LOCK_LAST) begin
                            state_d    = ST_SETTLE;
                            good_cnt_d = 8'd0;
                            tmr_d      = 10'd0;
                        end else begin
                            good_cnt_d = good_cnt_q + 8'd1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (fault) begin
                        state_d    = ST_WAIT_CLK;
                        good_cnt_d = 8'd0;
                    end else if (tmr_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        tmr_d = tmr_q + 10'd1;
                    end
                end
                ST_RUN: begin
                    if (fault) begin
                        state_d = ST_FAULT;
                        tmr_d   = 10'd0;
                        err_inc = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (tmr_q == HOLD_LAST) begin
                        state_d    = ST_WAIT_CLK;
                        good_cnt_d = 8'd0;
                    end else begin
                        tmr_d = tmr_q + 10'd1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end

        // A clear wins over a coincident fault increment.
        if (clr_err) begin
            err_d = '0;
        end else if (err_inc && (err_q != {W_ERR{1'b1}})) begin
            err_d = err_q + W_ERR'(1);
        end else begin
            err_d = err_q;
        end

        lane_rst_n_d = (state_d == ST_SETTLE) || (state_d == ST_RUN);
        out_en_d     = (state_d == ST_RUN);
        locked_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            en_s1_q      <= 1'b0;
            en_s2_q      <= 1'b0;
            pt_s1_q      <= 1'b0;
            pt_s2_q      <= 1'b0;
            pt_s3_q      <= 1'b0;
            ivl_q        <= 4'd0;
            state_q      <= ST_OFF;
            good_cnt_q   <= 8'd0;
            tmr_q        <= 10'd0;
            err_q        <= '0;
            lane_rst_n_q <= 1'b0;
            out_en_q     <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            en_s1_q      <= enable;
            en_s2_q      <= en_s1_q;
            pt_s1_q      <= pix_toggle;
            pt_s2_q      <= pt_s1_q;
            pt_s3_q      <= pt_s2_q;
            ivl_q        <= ivl_d;
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            tmr_q        <= tmr_d;
            err_q        <= err_d;
            lane_rst_n_q <= lane_rst_n_d;
            out_en_q     <= out_en_d;
            locked_q     <= locked_d;
        end
    end

    assign lane_rst_n = lane_rst_n_q;
    assign out_en     = out_en_q;
    assign locked     = locked_q;
    assign state      = state_q;
    assign err_count  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dvi_link_ctrl.sv
// ============================================================================
// Module   : tb_dvi_link_ctrl
// Brief    : Scoreboard bench for dvi_link_ctrl; expected output changes are
//            queued by the stimulus and matched by a negedge monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dvi_link_ctrl;

    localparam int W_ERR         = 2;
    localparam int SETTLE_CYCLES = 64;
    localparam int HOLD_CYCLES   = 32;

    logic             clk_x5     = 1'b0;
    logic             rst_n_x5   = 1'b0;
    logic             enable     = 1'b0;
    logic             pix_toggle = 1'b0;
    logic             clr_err    = 1'b0;
    logic             lane_rst_n;
    logic             out_en;
    logic             locked;
    logic [2:0]       state;
    logic [W_ERR-1:0] err_count;

    dvi_link_ctrl #(
        .LOCK_EDGES   (16),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .W_ERR        (W_ERR)
    ) dut (
        .clk_x5    (clk_x5),
        .rst_n_x5  (rst_n_x5),
        .enable    (enable),
        .pix_toggle(pix_toggle),
        .clr_err   (clr_err),
        .lane_rst_n(lane_rst_n),
        .out_en    (out_en),
        .locked    (locked),
        .state     (state),
        .err_count (err_count)
    );

    always #5 clk_x5 = ~clk_x5;

    int cyc = 0;
    always @(posedge clk_x5) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]       st;
        logic             lr;
        logic             oe;
        logic             lk;
        logic [W_ERR-1:0] err;
    } obs_t;

    typedef struct {
        obs_t  o;
        int    at;
        int    gap;
        string name;
    } exp_t;

    exp_t expq[$];
    int   total    = 0;
    int   bad      = 0;
    int   last_tog = 0;
    int   last_evt = 0;
    obs_t prev_obs = '0;
    obs_t cur_obs;
    exp_t e;

    task automatic chk_obs(input string nm, input obs_t got, input obs_t req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got st=%0d lane_rst_n=%0b out_en=%0b locked=%0b err=%0d, required st=%0d lane_rst_n=%0b out_en=%0b locked=%0b err=%0d",
                     nm, got.st, got.lr, got.oe, got.lk, got.err, req.st, req.lr, req.oe, req.lk, req.err);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    // Expected outputs for each state, as listed in the output table.
    task automatic push(input string nm, input int st, input int err, input int at, input int gap);
        exp_t x;
        x.o.st  = 3'(st);
        x.o.lr  = (st == 2) || (st == 3);
        x.o.oe  = (st == 3);
        x.o.lk  = (st == 3);
        x.o.err = W_ERR'(err);
        x.at    = at;
        x.gap   = gap;
        x.name  = nm;
        expq.push_back(x);
    endtask

    // Monitor: every change of the observable output tuple consumes one expectation.
    always @(negedge clk_x5) begin
        cur_obs = {state, lane_rst_n, out_en, locked, err_count};
        if (cur_obs !== prev_obs) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_change: got st=%0d out_en=%0b err=%0d at cyc %0d, required no change",
                         cur_obs.st, cur_obs.oe, cur_obs.err, cyc);
            end else begin
                e = expq.pop_front();
                chk_obs(e.name, cur_obs, e.o);
                if (e.at >= 0) chk_int({e.name, "_cycle"}, cyc, e.at);
                if (e.gap >= 0) chk_int({e.name, "_gap"}, cyc - last_evt, e.gap);
            end
            last_evt = cyc;
            prev_obs = cur_obs;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_x5);
        #1;
    endtask

    task automatic hb(input int n, input int per);
        repeat (n) begin
            tick(per);
            pix_toggle = ~pix_toggle;
            last_tog   = cyc;
        end
    endtask

    // Heartbeat has stopped in RUN: timeout 8 cycles after the last edge, then hold.
    task automatic stop_and_fault(input int exp_err, input bit do_clr);
        int c;
        c = last_tog;
        push("fault", 4, exp_err, c + 11, -1);
        push("retry", 1, exp_err, -1, HOLD_CYCLES);
        if (do_clr) begin
            while (cyc < c + 10) tick(1);
            clr_err = 1'b1;
            tick(1);
            clr_err = 1'b0;
        end
        while (cyc < c + 50) tick(1);
    endtask

    task automatic lock_up(input int n, input int exp_err);
        hb(n, 5);
        push("settle", 2, exp_err, last_tog + 3, -1);
        push("run", 3, exp_err, -1, SETTLE_CYCLES);
        hb(15, 5);
    endtask

    initial begin
        tick(3);
        chk_obs("reset_state", {state, lane_rst_n, out_en, locked, err_count}, '0);
        rst_n_x5 = 1'b1;
        tick(20);

        // Steady heartbeat: first edge after idle is bad, then 16 good edges.
        enable = 1'b1;
        push("enable", 1, 0, cyc + 3, -1);
        lock_up(17, 0);

        // Heartbeat loss in RUN and relock.
        stop_and_fault(1, 1'b0);
        lock_up(17, 1);

        // Short interval after 10 good edges restarts the lock count.
        stop_and_fault(2, 1'b0);
        hb(11, 5);
        hb(1, 3);
        hb(16, 5);
        push("settle_after_glitch", 2, 2, last_tog + 3, -1);

        // Long interval during SETTLE aborts back to WAIT_CLK without an error.
        hb(3, 5);
        hb(1, 7);
        push("settle_abort", 1, 2, last_tog + 3, -1);
        lock_up(16, 2);

        // Saturation of the 2-bit counter, then clear coincident with a fault.
        stop_and_fault(3, 1'b0);
        lock_up(17, 3);
        stop_and_fault(3, 1'b0);
        lock_up(17, 3);
        stop_and_fault(3, 1'b0);
        lock_up(17, 3);
        stop_and_fault(0, 1'b1);
        lock_up(17, 0);

        // Enable drop in RUN.
        hb(2, 5);
        enable = 1'b0;
        push("disable", 0, 0, cyc + 3, -1);
        tick(20);

        // Retry, then asynchronous reset mid-SETTLE.
        enable = 1'b1;
        push("reenable", 1, 0, cyc + 3, -1);
        hb(17, 5);
        push("settle_retry", 2, 0, last_tog + 3, -1);
        hb(4, 5);
        push("async_reset", 0, 0, -1, -1);
        @(posedge clk_x5);
        #2 rst_n_x5 = 1'b0;
        #1 chk_obs("async_reset_now", {state, lane_rst_n, out_en, locked, err_count}, '0);
        tick(4);
        @(posedge clk_x5);
        #2 rst_n_x5 = 1'b1;
        push("restart", 1, 0, cyc + 3, -1);
        tick(20);

        chk_int("pending_expectations", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by cyc %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
